// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with single-cycle results for divide-by-zero and overflow.
module muldiv_unit (
  input  logic        p_clk_i,
  input  logic        p_reset_i,
  input  logic        p_valid_i,
  input  logic [2:0]  p_funct3_i,
  input  logic [31:0] p_rs1_i,
  input  logic [31:0] p_rs2_i,
  input  logic        p_flush_i,
  output logic        p_ready_o,
  output logic        p_done_o,
  output logic [31:0] p_result_o
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: an operation is accepted on a rising edge where p_valid_i=1,
  // p_ready_o=1 and p_flush_i=0; p_done_o is a single-cycle pulse qualifying p_result_o.
  state_e      state_q,  state_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] op_q,     op_d;
  logic [31:0] acc_q,    acc_d;
  logic [31:0] lo_q,     lo_d;
  logic [31:0] result_q, result_d;
  logic        neg_q,    neg_d;
  logic        done_q,   done_d;

  logic        accept;
  logic        is_div_in;
  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic        div_zero_in;
  logic        ovf_in;
  logic        special_in;
  logic        neg_in;
  logic [31:0] special_res_in;

  assign accept      = (state_q == S_IDLE) && p_valid_i && !p_flush_i;
  assign is_div_in   = p_funct3_i[2];
  assign a_signed_in = (p_funct3_i != F_MULHU) && (p_funct3_i != F_DIVU) &&
                       (p_funct3_i != F_REMU);
  assign b_signed_in = a_signed_in && (p_funct3_i != F_MULHSU);
  assign a_neg_in    = a_signed_in && p_rs1_i[31];
  assign b_neg_in    = b_signed_in && p_rs2_i[31];
  assign a_mag_in    = a_neg_in ? (~p_rs1_i + 32'd1) : p_rs1_i;
  assign b_mag_in    = b_neg_in ? (~p_rs2_i + 32'd1) : p_rs2_i;
  assign div_zero_in = is_div_in && (p_rs2_i == 32'd0);
  assign ovf_in      = is_div_in && !p_funct3_i[0] &&
                       (p_rs1_i == 32'h8000_0000) && (p_rs2_i == 32'hFFFF_FFFF);
  assign special_in  = div_zero_in || ovf_in;
  // Remainder takes the dividend's sign; quotient and product take the xor.
  assign neg_in      = (is_div_in && p_funct3_i[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

  always_comb begin
    special_res_in = 32'd0;
    if (div_zero_in) begin
      special_res_in = p_funct3_i[1] ? p_rs1_i : 32'hFFFF_FFFF;
    end else if (ovf_in) begin
      special_res_in = p_funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step. Multiply: {acc,lo} holds {partial, multiplier}, shifted right.
  // Divide: acc is the partial remainder, lo shifts the dividend out and the quotient in.
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_diff;
  logic [31:0] acc_step;
  logic [31:0] lo_step;

  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, op_q} : 33'd0);
  assign rem_shift = {acc_q, lo_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, op_q};
  assign rem_diff  = rem_shift[31:0] - op_q;

  always_comb begin
    acc_step = acc_q;
    lo_step  = lo_q;
    if (funct3_q[2]) begin
      if (rem_ge) begin
        acc_step = rem_diff;
        lo_step  = {lo_q[30:0], 1'b1};
      end else begin
        acc_step = rem_shift[31:0];
        lo_step  = {lo_q[30:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[32:1];
      lo_step  = {mul_sum[0], lo_q[31:1]};
    end
  end

  // Sign correction applied to the values produced by the final step.
  logic [63:0] prod_raw;
  logic [63:0] prod_fix;
  logic [31:0] div_raw;
  logic [31:0] div_fix;
  logic [31:0] final_res;

  assign prod_raw = {acc_step, lo_step};
  assign prod_fix = neg_q ? (~prod_raw + 64'd1) : prod_raw;
  assign div_raw  = funct3_q[1] ? acc_step : lo_step;
  assign div_fix  = neg_q ? (~div_raw + 32'd1) : div_raw;

  always_comb begin
    final_res = 32'd0;
    if (funct3_q[2]) begin
      final_res = div_fix;
    end else if (funct3_q == F_MUL) begin
      final_res = prod_fix[31:0];
    end else begin
      final_res = prod_fix[63:32];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = p_funct3_i;
          neg_d    = neg_in;
          cnt_d    = 6'd0;
          acc_d    = 32'd0;
          if (is_div_in) begin
            op_d = b_mag_in;
            lo_d = a_mag_in;
          end else begin
            op_d = a_mag_in;
            lo_d = b_mag_in;
          end
          if (special_in) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res_in;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (p_flush_i) begin
          state_d = S_IDLE;
          acc_d   = 32'd0;
          lo_d    = 32'd0;
        end else begin
          acc_d = acc_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = final_res;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge p_clk_i) begin
    if (p_reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      funct3_q <= 3'd0;
      op_q     <= 32'd0;
      acc_q    <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  // A flush or reset arriving during the DONE cycle suppresses the pulse immediately.
  assign p_ready_o  = (state_q == S_IDLE) || p_reset_i;
  assign p_done_o   = done_q && !p_flush_i && !p_reset_i;
  assign p_result_o = p_done_o ? result_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic model
// of the RV32M multiply/divide results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic [2:0]  f3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready;
  logic        done;
  logic [31:0] res;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .p_clk_i    (clk),
    .p_reset_i  (rst),
    .p_valid_i  (valid),
    .p_funct3_i (f3),
    .p_rs1_i    (rs1),
    .p_rs2_i    (rs2),
    .p_flush_i  (flush),
    .p_ready_o  (ready),
    .p_done_o   (done),
    .p_result_o (res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      p;
    logic [63:0] pu;
    int          q;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      4: return 32'hFFFF_FFF0 | $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  // Issues one op, optionally holding p_valid_i high while busy, and checks
  // latency, result and the idle cycle that follows.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    int k;
    int lat;
    logic [31:0] e;
    wait_ready();
    valid = 1'b1; f3 = f; rs1 = a; rs2 = b;
    exp_q.push_back(ref_result(f, a, b));
    lat = ref_latency(f, a, b);
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
    f3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    k = 1;
    while (!done && k < 40) begin
      if (k == 1) begin
        check("busy_ready", {31'd0, ready}, 32'd0);
        check("busy_result", res, 32'd0);
      end
      @(posedge clk); #1;
      k++;
    end
    valid = 1'b0;
    check("latency", k, lat);
    e = exp_q.pop_front();
    check("result", res, e);
    @(posedge clk); #1;
    check("post_done", {31'd0, done}, 32'd0);
    check("post_ready", {31'd0, ready}, 32'd1);
    check("post_result", res, 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; f3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", res, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, ready}, 32'd1);

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd2, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd7, 32'd2, 1'b0);
    run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd7, 32'h0000_00AB, 32'd0, 1'b1);

    // Flush in the tenth CALC cycle.
    wait_ready();
    valid = 1'b1; f3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    check("flush_cycle_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    run_op(3'd0, 32'd3, 32'd5, 1'b0);

    // Flush coincident with valid in IDLE must not accept.
    wait_ready();
    valid = 1'b1; flush = 1'b1; f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    check("flush_idle_done", {31'd0, done}, 32'd0);

    // Reset in the twentieth CALC cycle, valid held high while busy.
    wait_ready();
    valid = 1'b1; f3 = 3'd1; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    repeat (19) begin @(posedge clk); #1; end
    valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", res, 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_done_after_rst", dones, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 p_clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 p_reset_i  in  1  reset, synchronous, active-high.
REQ-004 p_valid_i  in  1  decoded M-extension instruction presented (opcode 0110011, funct7 0000001).
REQ-005 p_funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 p_rs1_i  in  32  operand A (multiplicand / dividend).
REQ-007 p_rs2_i  in  32  operand B (multiplier / divisor).
REQ-008 p_flush_i  in  1  abort in-flight operation (pipeline kill).
REQ-009 p_ready_o  out  1  unit idle, can accept.
REQ-010 p_done_o  out  1  one-cycle pulse, result valid.
REQ-011 p_result_o  out  32  result; valid only while p_done_o=1, else 0.

Function
REQ-012 Accept occurs on a rising edge where p_valid_i=1, p_ready_o=1 and p_flush_i=0; operands and funct3 are registered at accept; later input changes have no effect.
REQ-013 States: IDLE, CALC, DONE; IDLE -> CALC on accept (normal op); IDLE -> DONE on accept (special case, REQ-019/020); CALC -> DONE after 32 iterations; DONE -> IDLE unconditionally.
REQ-014 p_ready_o=1 only in IDLE; p_valid_i outside IDLE is ignored, no queuing.
REQ-015 Latency: normal op, p_done_o high in the 33rd cycle after the accept edge (32 CALC cycles + 1 DONE cycle); special case, p_done_o high in the cycle immediately after accept.
REQ-016 Multiply: 32-step iterative shift-add on operand magnitudes, 64-bit product sign-corrected at DONE; MUL returns product[31:0], MULH/MULHSU/MULHU return product[63:32].
REQ-017 Signedness: MULH signed x signed; MULHSU rs1 signed x rs2 unsigned; MULHU/DIVU/REMU unsigned x unsigned; MUL low word identical for all signedness.
REQ-018 Divide: 32-step restoring division on magnitudes; quotient sign = sign(A) xor sign(B) for DIV; remainder sign = sign(A) for REM; quotient rounds toward zero.
REQ-019 Divide by zero (B=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = A; takes special-case path; no exception.
REQ-020 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV result 0x80000000, REM result 0; special-case path.
REQ-021 Iteration counter 6 bits, cleared at accept, CALC exits when it reaches 32; no wrap.
REQ-022 p_flush_i=1 in CALC or DONE: next state IDLE, p_done_o=0 that cycle and next, partial result discarded.
REQ-023 p_flush_i=1 coincident with p_valid_i in IDLE: no accept; unit stays IDLE.
REQ-024 Accept permitted in the cycle after DONE (back-to-back minimum spacing: one IDLE cycle).

Reset
REQ-025 p_reset_i=1 at a rising edge: state IDLE, counter 0, internal registers 0; overrides accept and flush in that cycle.
REQ-026 Output values while/after reset: p_ready_o=1, p_done_o=0, p_result_o=0.
REQ-027 Reset mid-CALC or in DONE aborts the operation; no p_done_o produced for it.

Verification
REQ-028 MULHU A=0xFFFFFFFF B=0xFFFFFFFF -> p_done_o 33 cycles after accept, result 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-029 MULHSU A=0xFFFFFFFF(-1) B=0xFFFFFFFF -> result 0xFFFFFFFF; MULH A=0xFFFFFFFD(-3) B=2 -> result 0xFFFFFFFF.
REQ-030 DIV A=0xFFFFFFF9(-7) B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU A=7 B=2 -> 3.
REQ-031 DIVU A=0x1234 B=0 -> 0xFFFFFFFF after 1 cycle; REM A=0x80000000 B=0xFFFFFFFF -> 0 after 1 cycle.
REQ-032 Accept DIV, assert p_flush_i at CALC cycle 10 -> p_ready_o=1 next cycle, no p_done_o; new MUL 3x5 accepted next -> result 15.
REQ-033 Assert p_reset_i at CALC cycle 20 -> next cycle p_ready_o=1, p_done_o=0, p_result_o=0; p_valid_i held high during busy never causes a second accept.
